// File: rtl/interrupt_controller.sv
// Interrupt controller: edge-captures source requests into IF, masks with IE,
// resolves lowest-index priority and returns a one-cycle ack on CPU acceptance.
module interrupt_controller #(
   parameter int          NUM_SRC = 5,
   parameter logic [15:0] IF_ADDR = 16'hFF0F,
   parameter logic [15:0] IE_ADDR = 16'hFFFF
) (
   input  logic               I_CLK33,
   input  logic               I_RESET_L,
   input  logic [NUM_SRC-1:0] I_INT_REQ,
   output logic [NUM_SRC-1:0] O_INT_ACK,
   input  logic               I_MEM_ENABLE,
   input  logic [15:0]        I_ADDR,
   input  logic [7:0]         I_DATA,
   input  logic               I_WE_L,
   input  logic               I_RE_L,
   output logic [7:0]         O_DATA,
   output logic               O_SELECT,
   output logic               O_INT_PENDING,
   output logic [15:0]        O_INT_VECTOR,
   input  logic               I_INT_ACCEPT
);

   localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   typedef enum logic {
      ST_IDLE,
      ST_ACK
   } state_t;

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     ack_idx_q, ack_idx_d;
   logic [NUM_SRC-1:0]   if_q, if_d;
   logic [7:0]           ie_q, ie_d;
   logic [NUM_SRC-1:0]   req_prev_q, req_prev_d;
   logic [7:0]           rdata_q, rdata_d;
   logic                 sel_q, sel_d;

   logic                 wr_if, wr_ie, rd_if, rd_ie;
   logic [NUM_SRC-1:0]   pend;
   logic [NUM_SRC-1:0]   req_rise;
   logic [IDX_W-1:0]     win_idx;
   logic                 take;

   always_comb begin
      wr_if = I_MEM_ENABLE && !I_WE_L && (I_ADDR == IF_ADDR);
      wr_ie = I_MEM_ENABLE && !I_WE_L && (I_ADDR == IE_ADDR);
      rd_if = I_MEM_ENABLE && !I_RE_L && (I_ADDR == IF_ADDR);
      rd_ie = I_MEM_ENABLE && !I_RE_L && (I_ADDR == IE_ADDR);
   end

   assign pend     = if_q & ie_q[NUM_SRC-1:0];
   assign req_rise = I_INT_REQ & ~req_prev_q;

   // Scan high to low so the lowest set index is the one left standing.
   always_comb begin
      win_idx = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (pend[i]) win_idx = IDX_W'(i);
      end
   end

   assign O_INT_PENDING = |pend;
   assign O_INT_VECTOR  = (|pend) ? (16'h0040 + (16'(win_idx) << 3)) : 16'h0000;

   assign take = (state_q == ST_IDLE) && I_INT_ACCEPT && (|pend);

   always_comb begin
      state_d   = state_q;
      ack_idx_d = ack_idx_q;
      case (state_q)
         ST_IDLE: begin
            if (take) begin
               state_d   = ST_ACK;
               ack_idx_d = win_idx;
            end
         end
         ST_ACK:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Per-bit precedence: bus write < acceptance clear < new request edge.
   always_comb begin
      if_d = if_q;
      if (wr_if) if_d = I_DATA[NUM_SRC-1:0];
      if (take) if_d[win_idx] = 1'b0;
      if_d       = if_d | req_rise;
      ie_d       = wr_ie ? I_DATA : ie_q;
      req_prev_d = I_INT_REQ;
   end

   always_comb begin
      rdata_d = 8'h00;
      sel_d   = 1'b0;
      if (rd_if) begin
         rdata_d                = 8'hFF;
         rdata_d[NUM_SRC-1:0]   = if_q;
         sel_d                  = 1'b1;
      end else if (rd_ie) begin
         rdata_d = ie_q;
         sel_d   = 1'b1;
      end
   end

   always_comb begin
      O_INT_ACK = '0;
      if (state_q == ST_ACK) O_INT_ACK[ack_idx_q] = 1'b1;
   end

   assign O_DATA   = rdata_q;
   assign O_SELECT = sel_q;

   always_ff @(posedge I_CLK33) begin
      if (!I_RESET_L) begin
         state_q    <= ST_IDLE;
         ack_idx_q  <= '0;
         if_q       <= '0;
         ie_q       <= 8'h00;
         req_prev_q <= '0;
         rdata_q    <= 8'h00;
         sel_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ack_idx_q  <= ack_idx_d;
         if_q       <= if_d;
         ie_q       <= ie_d;
         req_prev_q <= req_prev_d;
         rdata_q    <= rdata_d;
         sel_q      <= sel_d;
      end
   end

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: cycle model compared every cycle plus
// directed scenarios with literal expectations.
module tb_interrupt_controller;

   logic        clk = 1'b0;
   logic        rst_l = 1'b0;
   logic [4:0]  req = '0;
   logic [4:0]  ack;
   logic        en = 1'b0;
   logic [15:0] addr = '0;
   logic [7:0]  wdat = '0;
   logic        we_l = 1'b1;
   logic        re_l = 1'b1;
   logic [7:0]  rdat;
   logic        sel;
   logic        pending;
   logic [15:0] vec;
   logic        acc = 1'b0;

   int errors = 0;
   int checks = 0;
   bit cmp_en = 1'b0;

   interrupt_controller dut (
      .I_CLK33(clk), .I_RESET_L(rst_l), .I_INT_REQ(req), .O_INT_ACK(ack),
      .I_MEM_ENABLE(en), .I_ADDR(addr), .I_DATA(wdat), .I_WE_L(we_l), .I_RE_L(re_l),
      .O_DATA(rdat), .O_SELECT(sel), .O_INT_PENDING(pending), .O_INT_VECTOR(vec),
      .I_INT_ACCEPT(acc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int lowest(input logic [4:0] p);
      for (int i = 0; i < 5; i++) if (p[i]) return i;
      return -1;
   endfunction

   // Model state: flags as plain bit vectors, ack as "pulse owed this cycle".
   logic [4:0] m_if = '0, m_prev = '0;
   logic [7:0] m_ie = '0, m_rd = '0;
   bit         m_sel = 0, m_ack = 0;
   int         m_idx = 0;

   always @(posedge clk) begin
      logic [4:0] p, nif;
      int         w;
      bit         ok;
      if (!rst_l) begin
         m_if = '0; m_ie = '0; m_prev = '0; m_ack = 0; m_idx = 0; m_rd = '0; m_sel = 0;
      end else begin
         p  = m_if & m_ie[4:0];
         w  = lowest(p);
         ok = !m_ack && acc && (p != 0);
         if (en && !re_l && addr == 16'hFF0F) begin m_rd = {3'b111, m_if}; m_sel = 1; end
         else if (en && !re_l && addr == 16'hFFFF) begin m_rd = m_ie; m_sel = 1; end
         else begin m_rd = 8'h00; m_sel = 0; end
         nif = m_if;
         if (en && !we_l && addr == 16'hFF0F) nif = wdat[4:0];
         if (ok) nif[w] = 1'b0;
         nif = nif | (req & ~m_prev);
         if (en && !we_l && addr == 16'hFFFF) m_ie = wdat;
         m_ack  = ok;
         if (ok) m_idx = w;
         m_prev = req;
         m_if   = nif;
      end
   end

   always @(negedge clk) begin
      logic [4:0]  p;
      logic [15:0] ev;
      logic [4:0]  ea;
      if (cmp_en) begin
         p  = m_if & m_ie[4:0];
         ev = (p != 0) ? 16'(16'h0040 + 8 * lowest(p)) : 16'h0000;
         ea = m_ack ? 5'(1 << m_idx) : 5'b0;
         chk("model_ack", 16'(ack), 16'(ea));
         chk("model_pending", 16'(pending), 16'(p != 0));
         chk("model_vector", vec, ev);
         chk("model_data", 16'(rdat), 16'(m_rd));
         chk("model_select", 16'(sel), 16'(m_sel));
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      en = 1; we_l = 0; addr = a; wdat = d;
      tick();
      en = 0; we_l = 1;
   endtask

   task automatic rd_chk(input string name, input logic [15:0] a, input logic [7:0] exp);
      en = 1; re_l = 0; addr = a;
      tick();
      en = 0; re_l = 1;
      chk(name, 16'(rdat), 16'(exp));
      chk({name, "_sel"}, 16'(sel), 16'd1);
   endtask

   initial begin
      tick(); tick();
      cmp_en = 1;
      chk("rst_ack", 16'(ack), 16'h0);
      chk("rst_pending", 16'(pending), 16'h0);
      chk("rst_vector", vec, 16'h0);
      chk("rst_data", 16'(rdat), 16'h0);
      chk("rst_sel", 16'(sel), 16'h0);
      rst_l = 1;
      tick();

      // Single VBlank request
      wr(16'hFFFF, 8'h01);
      req = 5'b00001; tick();
      chk("vb_pending", 16'(pending), 16'h1);
      chk("vb_vector", vec, 16'h0040);
      req = 5'b00000;
      acc = 1; tick(); acc = 0;
      chk("vb_ack", 16'(ack), 16'h01);
      tick();
      chk("vb_ack_gone", 16'(ack), 16'h00);
      rd_chk("vb_if", 16'hFF0F, 8'hE0);
      rd_chk("vb_ie", 16'hFFFF, 8'h01);

      // Timer and joypad together
      wr(16'hFFFF, 8'h1F);
      req = 5'b10100; tick();
      chk("tj_vector1", vec, 16'h0050);
      acc = 1; tick(); acc = 0;
      chk("tj_ack1", 16'(ack), 16'h04);
      req = 5'b10000; tick();
      chk("tj_vector2", vec, 16'h0060);
      acc = 1; tick(); acc = 0;
      chk("tj_ack2", 16'(ack), 16'h10);
      req = 5'b00000; tick();
      chk("tj_pending", 16'(pending), 16'h0);

      // Masked LCDC request
      wr(16'hFFFF, 8'h00);
      req = 5'b00010; tick();
      rd_chk("mask_if", 16'hFF0F, 8'hE2);
      chk("mask_pending", 16'(pending), 16'h0);
      acc = 1; tick(); acc = 0;
      chk("mask_ack", 16'(ack), 16'h00);
      rd_chk("mask_if2", 16'hFF0F, 8'hE2);
      req = 5'b00000;
      wr(16'hFF0F, 8'h00);

      // Request edge beats IF write of 0
      req = 5'b00001; wr(16'hFF0F, 8'h00);
      rd_chk("set_vs_wr0", 16'hFF0F, 8'hE1);
      req = 5'b00000;

      // Accept clear beats IF write of 1
      wr(16'hFFFF, 8'h01);
      acc = 1; wr(16'hFF0F, 8'h01); acc = 0;
      chk("clr_vs_wr1_ack", 16'(ack), 16'h01);
      rd_chk("clr_vs_wr1_if", 16'hFF0F, 8'hE0);

      // Back-to-back accepts: one ack per two cycles
      wr(16'hFFFF, 8'h1F);
      req = 5'b00011; tick(); req = 5'b00000;
      acc = 1; tick();
      chk("tp_ack1", 16'(ack), 16'h01);
      tick();
      chk("tp_ack_gap", 16'(ack), 16'h00);
      tick();
      chk("tp_ack2", 16'(ack), 16'h02);
      acc = 0; tick();

      // Serial held through reset
      req = 5'b01000; rst_l = 0; tick(); tick();
      rst_l = 1; tick();
      rd_chk("hold_if", 16'hFF0F, 8'hE8);
      wr(16'hFFFF, 8'h08);
      chk("hold_vector", vec, 16'h0058);
      acc = 1; tick(); acc = 0;
      chk("hold_ack", 16'(ack), 16'h08);
      tick(); tick();
      rd_chk("hold_if_after", 16'hFF0F, 8'hE0);
      chk("hold_pending", 16'(pending), 16'h0);

      // Reset during ACK drops the pulse
      req = 5'b00000; tick();
      req = 5'b01000; tick();
      acc = 1; tick(); acc = 0;
      chk("rack_ack", 16'(ack), 16'h08);
      rst_l = 0; tick();
      chk("rack_ack0", 16'(ack), 16'h00);
      chk("rack_pending0", 16'(pending), 16'h0);
      chk("rack_vector0", vec, 16'h0000);
      chk("rack_data0", 16'(rdat), 16'h0);
      chk("rack_sel0", 16'(sel), 16'h0);
      rst_l = 1; req = 5'b00000; tick(); tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
